// File: rtl/sata_link_seq.sv
// Per-port SATA link bring-up sequencer: PHY reset, OOB start, timeouts, bounded retries, DET status.
// Optional debug counters on seq_dbg are enabled by defining SATA_LINK_SEQ_DBG_EN.
module sata_link_seq #(
  parameter int unsigned C_RST_CYCLES   = 16,
  parameter int unsigned C_LINK_TIMEOUT = 1500000,
  parameter int unsigned C_BACKOFF      = 7500,
  parameter int unsigned C_RETRY_MAX    = 3
) (
  input  logic        phyclk,
  input  logic        rst_n,
  input  logic        port_en,
  input  logic        comreset_req,
  input  logic        plllock,
  input  logic        CommInit,
  input  logic        linkup,
  output logic        phyreset,
  output logic        StartComm,
  output logic        link_ready,
  output logic [3:0]  det,
  output logic [2:0]  retry_cnt,
  output logic        fail,
  output logic [31:0] seq_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_PLL  = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT_LINK = 3'd4,
    ST_LINKED    = 3'd5,
    ST_BACKOFF   = 3'd6,
    ST_FAILED    = 3'd7
  } state_t;

  localparam logic [23:0] RST_LAST  = 24'(C_RST_CYCLES - 1);
  localparam logic [23:0] TMO_LAST  = 24'(C_LINK_TIMEOUT - 1);
  localparam logic [23:0] BO_LAST   = 24'(C_BACKOFF - 1);
  localparam logic [2:0]  RETRY_MAX = 3'(C_RETRY_MAX);

  localparam logic [3:0] DET_NONE = 4'd0;
  localparam logic [3:0] DET_SEEN = 4'd1;
  localparam logic [3:0] DET_EST  = 4'd3;
  localparam logic [3:0] DET_OFF  = 4'd4;

  state_t      state, state_n;
  logic [23:0] timer, timer_n;
  logic [3:0]  det_n;
  logic [2:0]  retry_n;
  logic        restart;
  logic        entering;

  always_comb begin
    state_n = state;
    det_n   = det;
    retry_n = retry_cnt;
    restart = 1'b0;

    if (!port_en) begin
      state_n = ST_IDLE;
      det_n   = DET_OFF;
      retry_n = '0;
    end else if (comreset_req && (state != ST_IDLE)) begin
      state_n = ST_RESET;
      restart = 1'b1;
      retry_n = '0;
    end else begin
      case (state)
        ST_IDLE:     state_n = ST_RESET;
        ST_RESET:    if (timer == RST_LAST) state_n = ST_WAIT_PLL;
        ST_WAIT_PLL: begin
          if (plllock)                state_n = ST_START;
          else if (timer == TMO_LAST) state_n = ST_BACKOFF;
        end
        ST_START:    state_n = ST_WAIT_LINK;
        ST_WAIT_LINK: begin
          if (CommInit)               det_n   = DET_SEEN;
          if (linkup)                 state_n = ST_LINKED;
          else if (timer == TMO_LAST) state_n = ST_BACKOFF;
        end
        ST_LINKED: begin
          if (!linkup) begin
            state_n = ST_BACKOFF;
            det_n   = DET_SEEN;
          end
        end
        ST_BACKOFF: begin
          if (timer == BO_LAST)
            state_n = (retry_cnt >= RETRY_MAX) ? ST_FAILED : ST_RESET;
        end
        ST_FAILED:   state_n = ST_FAILED;
        default:     state_n = ST_IDLE;
      endcase
    end

    entering = restart || (state_n != state);

    // Entry side effects are keyed off the next state so every path into a state behaves alike
    if (entering && (state_n == ST_RESET))
      det_n = DET_NONE;
    if (state_n == ST_LINKED) begin
      det_n   = DET_EST;
      retry_n = '0;
    end
    if (entering && (state_n == ST_BACKOFF))
      retry_n = (retry_cnt == 3'd7) ? 3'd7 : retry_cnt + 3'd1;

    if (entering)
      timer_n = '0;
    else if (state inside {ST_RESET, ST_WAIT_PLL, ST_WAIT_LINK, ST_BACKOFF})
      timer_n = timer + 24'd1;
    else
      timer_n = timer;
  end

  always_ff @(posedge phyclk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      timer      <= '0;
      phyreset   <= 1'b1;
      StartComm  <= 1'b0;
      link_ready <= 1'b0;
      det        <= DET_OFF;
      retry_cnt  <= '0;
      fail       <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      det        <= det_n;
      retry_cnt  <= retry_n;
      phyreset   <= state_n inside {ST_IDLE, ST_RESET, ST_FAILED};
      StartComm  <= (state_n == ST_START);
      link_ready <= (state_n == ST_LINKED);
      fail       <= (state_n == ST_FAILED);
    end
  end

`ifdef SATA_LINK_SEQ_DBG_EN
  logic [7:0] drop_cnt;
  logic [7:0] tmo_cnt;
  logic       drop_ev;
  logic       tmo_ev;

  assign drop_ev = (state == ST_LINKED) && (state_n == ST_BACKOFF);
  assign tmo_ev  = ((state == ST_WAIT_PLL) || (state == ST_WAIT_LINK)) && (state_n == ST_BACKOFF);

  always_ff @(posedge phyclk) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      if (drop_ev && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      if (tmo_ev && (tmo_cnt != 8'hFF))   tmo_cnt  <= tmo_cnt + 8'd1;
    end
  end

  assign seq_dbg = {8'h00, tmo_cnt, drop_cnt, det, 1'b0, state};
`else
  assign seq_dbg = '0;
`endif

endmodule

// File: tb/tb_sata_link_seq.sv
// Self-checking bench for sata_link_seq: directed scenarios plus weighted-random stimulus
// compared every cycle against a phase/countdown reference model.
module tb_sata_link_seq;

  localparam int TB_RST  = 4;
  localparam int TB_TMO  = 100;
  localparam int TB_BO   = 8;
  localparam int TB_RMAX = 3;

  logic        phyclk = 1'b0;
  logic        rst_n, port_en, comreset_req, plllock, CommInit, linkup;
  logic        phyreset, StartComm, link_ready, fail;
  logic [3:0]  det;
  logic [2:0]  retry_cnt;
  logic [31:0] seq_dbg;

  int n_vec = 0;
  int n_err = 0;

  always #5 phyclk = ~phyclk;

  sata_link_seq #(
    .C_RST_CYCLES  (TB_RST),
    .C_LINK_TIMEOUT(TB_TMO),
    .C_BACKOFF     (TB_BO),
    .C_RETRY_MAX   (TB_RMAX)
  ) dut (
    .phyclk      (phyclk),
    .rst_n       (rst_n),
    .port_en     (port_en),
    .comreset_req(comreset_req),
    .plllock     (plllock),
    .CommInit    (CommInit),
    .linkup      (linkup),
    .phyreset    (phyreset),
    .StartComm   (StartComm),
    .link_ready  (link_ready),
    .det         (det),
    .retry_cnt   (retry_cnt),
    .fail        (fail),
    .seq_dbg     (seq_dbg)
  );

  // Reference model: current phase plus cycles left in it.
  typedef enum int {M_IDLE, M_RESET, M_PLL, M_START, M_LINK, M_LINKED, M_BACKOFF, M_FAILED} mph_t;
  mph_t       m_ph = M_IDLE;
  int         m_left = 0;
  logic [3:0] m_det = 4'd4;
  int         m_retry = 0;
  int         m_drops = 0;
  int         m_tmos = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic enter(input mph_t p);
    m_ph = p;
    case (p)
      M_RESET:        m_left = TB_RST;
      M_PLL, M_LINK:  m_left = TB_TMO;
      M_BACKOFF:      m_left = TB_BO;
      default:        m_left = 0;
    endcase
  endtask

  task automatic go_backoff();
    enter(M_BACKOFF);
    if (m_retry < 7) m_retry++;
  endtask

  task automatic timeout_hit();
    if (m_tmos < 255) m_tmos++;
    go_backoff();
  endtask

  task automatic model_step();
    if (!rst_n) begin
      enter(M_IDLE); m_det = 4'd4; m_retry = 0; m_drops = 0; m_tmos = 0;
    end else if (!port_en) begin
      enter(M_IDLE); m_det = 4'd4; m_retry = 0;
    end else if (comreset_req && m_ph != M_IDLE) begin
      enter(M_RESET); m_det = 4'd0; m_retry = 0;
    end else begin
      case (m_ph)
        M_IDLE: begin enter(M_RESET); m_det = 4'd0; end
        M_RESET: begin
          m_left--;
          if (m_left == 0) enter(M_PLL);
        end
        M_PLL: begin
          if (plllock) enter(M_START);
          else begin
            m_left--;
            if (m_left == 0) timeout_hit();
          end
        end
        M_START: enter(M_LINK);
        M_LINK: begin
          if (CommInit) m_det = 4'd1;
          if (linkup) begin
            enter(M_LINKED); m_det = 4'd3; m_retry = 0;
          end else begin
            m_left--;
            if (m_left == 0) timeout_hit();
          end
        end
        M_LINKED: begin
          if (!linkup) begin
            if (m_drops < 255) m_drops++;
            m_det = 4'd1;
            go_backoff();
          end
        end
        M_BACKOFF: begin
          m_left--;
          if (m_left == 0) begin
            if (m_retry >= TB_RMAX) enter(M_FAILED);
            else begin enter(M_RESET); m_det = 4'd0; end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_dbg;
    check("phyreset",   32'(phyreset),   32'(m_ph inside {M_IDLE, M_RESET, M_FAILED}));
    check("StartComm",  32'(StartComm),  32'(m_ph == M_START));
    check("link_ready", 32'(link_ready), 32'(m_ph == M_LINKED));
    check("fail",       32'(fail),       32'(m_ph == M_FAILED));
    check("det",        32'(det),        32'(m_det));
    check("retry_cnt",  32'(retry_cnt),  32'(m_retry));
`ifdef SATA_LINK_SEQ_DBG_EN
    exp_dbg = {8'h00, 8'(m_tmos), 8'(m_drops), m_det, 4'(int'(m_ph))};
`else
    exp_dbg = 32'h0;
`endif
    check("seq_dbg", seq_dbg, exp_dbg);
  endtask

  task automatic cyc();
    @(posedge phyclk);
    model_step();
    @(negedge phyclk);
    compare_all();
  endtask

  task automatic wait_start(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (StartComm) begin seen = 1'b1; break; end
    end
    if (!seen) check("start_wait", 32'(StartComm), 32'd1);
  endtask

  initial begin
    int pr_cnt, starts, hi, n;
    bit seen;

    rst_n = 1'b0; port_en = 1'b0; comreset_req = 1'b0;
    plllock = 1'b0; CommInit = 1'b0; linkup = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // Normal bring-up
    port_en = 1'b1; plllock = 1'b1;
    pr_cnt = 0; starts = 0; seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cyc();
      if (phyreset) pr_cnt++;
      if (StartComm) begin starts++; seen = 1'b1; end
    end
    repeat (20) begin cyc(); if (StartComm) starts++; end
    linkup = 1'b1;
    repeat (3) begin cyc(); if (StartComm) starts++; end
    check("bringup_phyreset_cycles", 32'(pr_cnt), 32'(TB_RST));
    check("bringup_start_pulses", 32'(starts), 32'd1);
    check("bringup_ready", 32'(link_ready), 32'd1);
    check("bringup_det", 32'(det), 32'd3);
    check("bringup_retry", 32'(retry_cnt), 32'd0);

    // Link drop
    linkup = 1'b0;
    cyc();
    check("drop_ready", 32'(link_ready), 32'd0);
    check("drop_det", 32'(det), 32'd1);
`ifdef SATA_LINK_SEQ_DBG_EN
    check("drop_dbg_count", 32'(seq_dbg[15:8]), 32'd1);
`endif
    repeat (TB_BO - 1) cyc();
    check("drop_backoff_phyreset", 32'(phyreset), 32'd0);
    cyc();
    check("drop_reattempt_phyreset", 32'(phyreset), 32'd1);
    wait_start(60);
    linkup = 1'b1;
    repeat (3) cyc();

    // comreset during cycle 2 of RESET
    comreset_req = 1'b1; cyc(); comreset_req = 1'b0;
    cyc();
    comreset_req = 1'b1; cyc(); comreset_req = 1'b0;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (phyreset) hi++;
      else break;
      cyc();
    end
    check("comreset_rst_hold", 32'(hi), 32'(TB_RST));
    repeat (5) cyc();

    // port_en drop coinciding with comreset
    port_en = 1'b0; comreset_req = 1'b1;
    cyc();
    comreset_req = 1'b0;
    check("offline_det", 32'(det), 32'd4);
    check("offline_phyreset", 32'(phyreset), 32'd1);

    // linkup on the last WAIT_LINK cycle
    port_en = 1'b1; linkup = 1'b0;
    wait_start(60);
    repeat (TB_TMO) cyc();
    linkup = 1'b1;
    cyc();
    check("edge_linkup_ready", 32'(link_ready), 32'd1);
    check("edge_linkup_retry", 32'(retry_cnt), 32'd0);
    cyc();

    // No device: three failed attempts then FAILED
    linkup = 1'b0; comreset_req = 1'b1;
    cyc();
    comreset_req = 1'b0;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      cyc(); n++;
      if (fail) begin seen = 1'b1; break; end
    end
    if (!seen) check("fail_wait", 32'(fail), 32'd1);
    check("fail_latency", 32'(n), 32'(TB_RMAX * (TB_RST + 1 + 1 + TB_TMO + TB_BO)));
    repeat (10) cyc();
    check("failed_fail", 32'(fail), 32'd1);
    check("failed_phyreset", 32'(phyreset), 32'd1);
    check("failed_retry", 32'(retry_cnt), 32'(TB_RMAX));
    comreset_req = 1'b1;
    cyc();
    comreset_req = 1'b0;
    check("restart_retry", 32'(retry_cnt), 32'd0);
    check("restart_fail", 32'(fail), 32'd0);

    // CommInit at cycle 10 of WAIT_LINK, no linkup
    wait_start(60);
    repeat (10) cyc();
    CommInit = 1'b1; cyc(); CommInit = 1'b0;
    check("cominit_det", 32'(det), 32'd1);
    repeat (TB_TMO - 10) cyc();
    check("cominit_backoff_det", 32'(det), 32'd1);
    check("cominit_backoff_retry", 32'(retry_cnt), 32'd1);
    repeat (TB_BO + 2) cyc();

    // Weighted random traffic
    for (int i = 0; i < 4000; i++) begin
      rst_n        = ($urandom_range(0, 599) != 0);
      if (port_en) port_en = ($urandom_range(0, 299) != 0);
      else         port_en = ($urandom_range(0, 3) == 0);
      comreset_req = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) plllock = ~plllock;
      if ($urandom_range(0, 29) == 0) linkup = ~linkup;
      CommInit     = ($urandom_range(0, 49) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
